mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle multiply/divide controller for the pipelined MIPS core. It decodes the E-stage opcode and function fields, launches `mult`/`multu`/`div`/`divu`, and holds the HI/LO registers. A busy counter models the real latency of each operation. It also raises the D-stage stall whenever a multiply/divide-class instruction would issue while the unit is busy or starting.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu` (≥2).
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu` (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `e_op`  in  6  E-stage instruction bits [31:26].
- `e_func`  in  6  E-stage instruction bits [5:0].
- `e_valid`  in  1  E-stage holds a real (non-bubble) instruction.
- `rs_val`  in  32  forwarded rs operand in E.
- `rt_val`  in  32  forwarded rt operand in E.
- `d_op`  in  6  D-stage bits [31:26].
- `d_func`  in  6  D-stage bits [5:0].
- `busy`  out  1  operation in progress.
- `stall`  out  1  freeze PC/D, insert bubble into E.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `md_rdata`  out  32  `hi` when E holds `mfhi`, else `lo`.

## Operation
- MD class means `e_op`/`d_op` = 000000 with func in {`mult` 011000, `multu` 011001, `div` 011010, `divu` 011011, `mthi` 010001, `mtlo` 010011, `mfhi` 010000, `mflo` 010010}.
- `start` (internal, combinational) = `e_valid` & !`busy` & E func ∈ {mult, multu, div, divu}.
- States: IDLE (`busy`=0, count=0) and RUN (`busy`=1, count>0).
- IDLE→RUN on the edge where `start`=1.
  - Count loads `MULT_CYCLES` or `DIV_CYCLES`.
  - The full 64-bit result is computed from `rs_val`/`rt_val` at that edge and held in a pending register.
  - A divide by zero is flagged at that edge.
- In RUN, each edge decrements count. On the edge where count==1:
  - HI/LO load the pending result, unless the operation was a divide by zero.
  - Go to IDLE.
- Arithmetic:
  - `mult`: signed 32×32→64, {HI,LO} = product.
  - `multu`: unsigned 32×32→64, {HI,LO} = product.
  - `div`: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - `divu`: unsigned; LO = quotient, HI = remainder.
  - Divisor 0: HI/LO unchanged; busy still runs the full `DIV_CYCLES`.
- `mthi`/`mtlo`: when `e_valid` & !`busy`, HI (or LO) ← `rs_val` at the next edge. No busy period.
- `stall` = D is MD class & (`busy` | `start`). Non-MD instructions never stall here.
- While `busy`, no E-stage MD instruction is accepted. The stall guarantees none arrives; if one does, it is ignored.
- Reset (`reset`=0, any time including mid-RUN):
  - `busy`=0, count=0, `hi`=0, `lo`=0, pending result cleared, `stall`=0 apart from combinational decode.
  - An in-flight operation is abandoned and never writes HI/LO.

## Timing
- Start at edge T → `busy`=1 during cycles T+1 … T+N, where N = selected cycle count.
- HI/LO hold the new value from edge T+N onward. `busy` falls at T+N.
- `stall` is combinational:
  - In the start cycle it asserts for an MD instruction in D.
  - It stays asserted through the last busy cycle.
  - The D instruction issues into E in the cycle after `busy` falls and sees the updated HI/LO.
- `md_rdata` is combinational from `hi`/`lo`/`e_func`: zero latency for `mfhi`/`mflo` in E.
- Back-to-back: a new start is accepted in the first cycle with `busy`=0. Minimum spacing is N+1 edges between starts.

## Test plan
- Reset then `mult` with rs=0xFFFFFFFE, rt=3:
  - `busy` high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - `multu` with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- `div` rs=0xFFFFFFF9 (−7), rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. `divu` 7/2 → LO=3, HI=1.
- `div` by 0 with HI=0x11, LO=0x22 preloaded via `mthi`/`mtlo`: `busy` 10 cycles, HI/LO remain 0x11/0x22.
- `mult` in E with `mflo` in D:
  - `stall`=1 for the start cycle plus all 5 busy cycles.
  - `mflo` then reaches E and `md_rdata` equals the new LO.
  - An `addu` in D during busy causes no stall.
- Drop `reset` low at busy cycle 3 of a `div`: `busy`/`hi`/`lo` go to 0 immediately (asynchronously), and no later write occurs.
- 0x80000000 `div` 0xFFFFFFFF → LO=0x80000000, HI=0. Then issue `mthi` rs=0xABCD in the first idle cycle → HI=0xABCD next edge.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: launches mult/div ops, models their latency,
// owns HI/LO and raises the D-stage stall for MD-class instructions while busy or starting.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  e_op,
    input  logic [5:0]  e_func,
    input  logic        e_valid,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [5:0]  d_op,
    input  logic [5:0]  d_func,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] F_MFHI     = 6'b010000;
    localparam logic [5:0] F_MTHI     = 6'b010001;
    localparam logic [5:0] F_MFLO     = 6'b010010;
    localparam logic [5:0] F_MTLO     = 6'b010011;
    localparam logic [5:0] F_MULT     = 6'b011000;
    localparam logic [5:0] F_MULTU    = 6'b011001;
    localparam logic [5:0] F_DIV      = 6'b011010;
    localparam logic [5:0] F_DIVU     = 6'b011011;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [63:0]     pend;
    logic            pend_dz;

    logic            e_special;
    logic            start;
    logic            e_is_div;
    logic            div_zero;
    logic [31:0]     safe_rt;
    logic [31:0]     q_s, r_s, q_u, r_u;
    logic [63:0]     mul_s, mul_u, result;

    function automatic logic is_md(input logic [5:0] op, input logic [5:0] func);
        return (op == OP_SPECIAL) &&
               (func == F_MULT || func == F_MULTU || func == F_DIV  || func == F_DIVU ||
                func == F_MTHI || func == F_MTLO  || func == F_MFHI || func == F_MFLO);
    endfunction

    assign e_special = e_valid && !busy && (e_op == OP_SPECIAL);
    assign start     = e_special && (e_func == F_MULT || e_func == F_MULTU ||
                                     e_func == F_DIV  || e_func == F_DIVU);
    assign e_is_div  = e_func[1];
    assign stall     = is_md(d_op, d_func) && (busy || start);
    assign md_rdata  = (e_op == OP_SPECIAL && e_func == F_MFHI) ? hi : lo;

    // Full-width result for the op in E; divisor forced non-zero so the divider never sees 0.
    always_comb begin
        div_zero = (rt_val == 32'd0);
        safe_rt  = div_zero ? 32'd1 : rt_val;
        mul_s    = 64'($signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val}));
        mul_u    = {32'd0, rs_val} * {32'd0, rt_val};
        q_u      = rs_val / safe_rt;
        r_u      = rs_val % safe_rt;
        q_s      = 32'($signed(rs_val) / $signed(safe_rt));
        r_s      = 32'($signed(rs_val) % $signed(safe_rt));
        // Dividing by -1 is a plain negation; this also pins INT_MIN / -1 to INT_MIN, rem 0.
        if (rt_val == 32'hFFFF_FFFF) begin
            q_s = 32'(32'd0 - rs_val);
            r_s = 32'd0;
        end
        case (e_func)
            F_MULT:  result = mul_s;
            F_MULTU: result = mul_u;
            F_DIV:   result = {r_s, q_s};
            default: result = {r_u, q_u};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            count   <= '0;
            pend    <= '0;
            pend_dz <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        count   <= e_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        pend    <= result;
                        pend_dz <= e_is_div && div_zero;
                    end else if (e_special && e_func == F_MTHI) begin
                        hi <= rs_val;
                    end else if (e_special && e_func == F_MTLO) begin
                        lo <= rs_val;
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!pend_dz) begin
                            hi <= pend[63:32];
                            lo <= pend[31:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, divide-by-zero, stall and reset behaviour.
module tb_mdu_ctrl;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADDU  = 6'b100001;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  e_op, e_func, d_op, d_func;
    logic        e_valid;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall;
    logic [31:0] hi, lo, md_rdata;

    int nvec = 0;
    int nerr = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .e_op(e_op), .e_func(e_func), .e_valid(e_valid),
        .rs_val(rs_val), .rt_val(rt_val), .d_op(d_op), .d_func(d_func),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo), .md_rdata(md_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in E for exactly one edge, then bubble.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        e_op = 6'd0; e_func = f; rs_val = a; rt_val = b; e_valid = 1'b1;
        tick();
        e_valid = 1'b0;
    endtask

    task automatic test_reset();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL reset_hi: got %h expected 0", hi); end
        nvec++; if (lo !== 32'd0) begin nerr++; $display("FAIL reset_lo: got %h expected 0", lo); end
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b expected 0", stall); end
    endtask

    task automatic test_mult();
        issue(F_MULT, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < 5; i++) begin
            nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL mult_busy[%0d]: got %b expected 1", i, busy); end
            tick();
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mult_busy_end: got %b expected 0", busy); end
        nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        nvec++; if (lo !== 32'hFFFF_FFFA) begin nerr++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
        // multu launched in the very first idle cycle
        issue(F_MULTU, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < 5; i++) begin
            nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL multu_busy[%0d]: got %b expected 1", i, busy); end
            tick();
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL multu_busy_end: got %b expected 0", busy); end
        nvec++; if (hi !== 32'h0000_0002) begin nerr++; $display("FAIL multu_hi: got %h expected 00000002", hi); end
        nvec++; if (lo !== 32'hFFFF_FFFA) begin nerr++; $display("FAIL multu_lo: got %h expected fffffffa", lo); end
    endtask

    task automatic test_div();
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 10; i++) begin
            nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL div_busy[%0d]: got %b expected 1", i, busy); end
            tick();
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL div_busy_end: got %b expected 0", busy); end
        nvec++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
        nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
        issue(F_DIVU, 32'd7, 32'd2);
        repeat (10) tick();
        nvec++; if (lo !== 32'd3) begin nerr++; $display("FAIL divu_lo: got %h expected 00000003", lo); end
        nvec++; if (hi !== 32'd1) begin nerr++; $display("FAIL divu_hi: got %h expected 00000001", hi); end
    endtask

    task automatic test_div_zero();
        issue(F_MTHI, 32'h11, 32'd0);
        issue(F_MTLO, 32'h22, 32'd0);
        nvec++; if (hi !== 32'h11) begin nerr++; $display("FAIL mthi_pre: got %h expected 00000011", hi); end
        nvec++; if (lo !== 32'h22) begin nerr++; $display("FAIL mtlo_pre: got %h expected 00000022", lo); end
        issue(F_DIV, 32'd5, 32'd0);
        for (int i = 0; i < 10; i++) begin
            nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL dz_busy[%0d]: got %b expected 1", i, busy); end
            // an MD op reaching E while busy must be ignored
            if (i == 3) begin
                e_func = F_MTLO; rs_val = 32'h99; e_valid = 1'b1;
            end else begin
                e_valid = 1'b0;
            end
            tick();
        end
        e_valid = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL dz_busy_end: got %b expected 0", busy); end
        nvec++; if (hi !== 32'h11) begin nerr++; $display("FAIL dz_hi: got %h expected 00000011", hi); end
        nvec++; if (lo !== 32'h22) begin nerr++; $display("FAIL dz_lo: got %h expected 00000022", lo); end
    endtask

    task automatic test_stall();
        d_op = 6'd0; d_func = F_MFLO;
        e_op = 6'd0; e_func = F_MULT; rs_val = 32'h0001_0000; rt_val = 32'h0001_0001; e_valid = 1'b1;
        #1;
        nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL stall_start: got %b expected 1", stall); end
        tick();
        e_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d_func = (i == 2) ? F_ADDU : F_MFLO;
            #1;
            nvec++;
            if (stall !== (i != 2)) begin
                nerr++; $display("FAIL stall_busy[%0d]: got %b expected %b", i, stall, (i != 2));
            end
            tick();
        end
        d_func = F_MFLO;
        #1;
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL stall_release: got %b expected 0", stall); end
        e_func = F_MFLO; e_valid = 1'b1; d_func = 6'd0;
        #1;
        nvec++; if (md_rdata !== 32'h0001_0000) begin nerr++; $display("FAIL mflo_rdata: got %h expected 00010000", md_rdata); end
        e_func = F_MFHI;
        #1;
        nvec++; if (md_rdata !== 32'h0000_0001) begin nerr++; $display("FAIL mfhi_rdata: got %h expected 00000001", md_rdata); end
        e_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        issue(F_DIV, 32'd100, 32'd7);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL rst_mid_hi: got %h expected 0", hi); end
        nvec++; if (lo !== 32'd0) begin nerr++; $display("FAIL rst_mid_lo: got %h expected 0", lo); end
        tick();
        reset = 1'b1;
        repeat (12) tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_after_busy: got %b expected 0", busy); end
        nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL rst_after_hi: got %h expected 0", hi); end
        nvec++; if (lo !== 32'd0) begin nerr++; $display("FAIL rst_after_lo: got %h expected 0", lo); end
    endtask

    task automatic test_back_to_back();
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (10) tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL ovf_busy_end: got %b expected 0", busy); end
        nvec++; if (lo !== 32'h8000_0000) begin nerr++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
        nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL ovf_hi: got %h expected 0", hi); end
        issue(F_MTHI, 32'h0000_ABCD, 32'd0);
        nvec++; if (hi !== 32'h0000_ABCD) begin nerr++; $display("FAIL b2b_mthi: got %h expected 0000abcd", hi); end
        nvec++; if (lo !== 32'h8000_0000) begin nerr++; $display("FAIL b2b_lo_kept: got %h expected 80000000", lo); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL b2b_mthi_busy: got %b expected 0", busy); end
    endtask

    initial begin
        reset = 1'b0;
        e_op = 6'd0; e_func = 6'd0; e_valid = 1'b0;
        rs_val = 32'd0; rt_val = 32'd0;
        d_op = 6'd0; d_func = F_MFLO;
        repeat (2) tick();
        test_reset();
        reset = 1'b1;
        d_func = 6'd0;
        tick();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
